// File: rtl/vic_pkg.sv
// vic_pkg: shared constants, FSM state and stack entry type for the VIC nesting scheduler.
package vic_pkg;
   localparam int N_IRQ   = 31;
   localparam int VEC_W   = 5;
   localparam int PRIO_W  = 3;
   localparam int DEPTH   = 4;
   localparam int TO_CYC  = 64;
   localparam int DEPTH_W = $clog2(DEPTH + 1);
   typedef enum logic {IDLE, REQ} state_t;
   typedef struct packed {
      logic [VEC_W-1:0]  vec;
      logic [PRIO_W-1:0] prio;
   } entry_t;
endpackage

// File: rtl/vic_prio_stack.sv
// vic_prio_stack: LIFO of active {vector, priority} entries; a same-cycle push+pop replaces the top.
module vic_prio_stack
   import vic_pkg::*;
#(
   parameter int N = 4,
   localparam int DW = $clog2(N + 1),
   localparam int AW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  entry_t        din,
   output entry_t        top,
   output logic [DW-1:0] depth,
   output logic          full,
   output logic          empty
);
   entry_t        mem [N];
   logic [DW-1:0] tm1;
   assign tm1   = depth - DW'(1);
   assign full  = depth == DW'(N);
   assign empty = depth == '0;
   assign top   = empty ? '0 : mem[tm1[AW-1:0]];
   always_ff @(posedge clk)
      if (rst) depth <= '0;
      else if (pop && !empty && push) mem[tm1[AW-1:0]] <= din;
      else if (pop && !empty) depth <= tm1;
      else if (push && !full) begin
         mem[depth[AW-1:0]] <= din;
         depth <= depth + DW'(1);
      end
endmodule

// File: rtl/vic_nest_ctrl.sv
// vic_nest_ctrl: forwards vic_irq vectors to the CPU only when they out-prioritise the active level.
// Optional macro VIC_NEST_TIMEOUT_EN abandons a CPU request after TO_CYC cycles without acknowledge.
module vic_nest_ctrl
   import vic_pkg::*;
(
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_irq_req,
   input  logic [VEC_W-1:0]        i_irq_addr,
   input  logic [N_IRQ*PRIO_W-1:0] i_prio,
   output logic                    o_irq_ack,
   output logic                    o_cpu_irq,
   output logic [VEC_W-1:0]        o_cpu_vec,
   input  logic                    i_cpu_ack,
   input  logic                    i_cpu_eoi,
   output logic [PRIO_W-1:0]       o_cur_prio,
   output logic [DEPTH_W-1:0]      o_depth,
   output logic                    o_full,
   output logic                    o_err,
   output logic                    o_timeout
);
   state_t            state, state_nx;
   logic [VEC_W-1:0]  vec;
   logic [PRIO_W-1:0] prio, p;
   logic [PRIO_W-1:0] prio_tbl [2**VEC_W];
   logic              accept, take, tmo, empty, ack, err;
   entry_t            ent, top;
   // vectors beyond the implemented lines read as priority 0 and are never accepted
   for (genvar k = 0; k < 2**VEC_W; k++) begin : g_prio
      if (k < N_IRQ) begin : g_on
         assign prio_tbl[k] = i_prio[k*PRIO_W +: PRIO_W];
      end else begin : g_off
         assign prio_tbl[k] = '0;
      end
   end
   assign p      = prio_tbl[i_irq_addr];
   assign accept = (state == IDLE) && i_irq_req && (p > o_cur_prio) && !o_full;
   assign take   = (state == REQ) && i_cpu_ack;
   assign ent    = {vec, prio};
   always_comb begin
      state_nx = state;
      state_nx = (state == IDLE) ? (accept ? REQ : IDLE) : ((i_cpu_ack || tmo) ? IDLE : REQ);
   end
   always_ff @(posedge i_clk)
      if (i_rst) begin
         state <= IDLE;
         vec   <= '0;
         prio  <= '0;
         ack   <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_nx;
         ack   <= accept;
         if (accept) begin
            vec  <= i_irq_addr;
            prio <= p;
         end
         if (i_cpu_eoi && empty) err <= 1'b1;
      end
`ifdef VIC_NEST_TIMEOUT_EN
   localparam int CW = $clog2(TO_CYC + 1);
   logic [CW-1:0] cnt;
   logic          to_flag;
   assign tmo = (state == REQ) && !i_cpu_ack && (cnt == CW'(TO_CYC - 1));
   always_ff @(posedge i_clk)
      if (i_rst) begin
         cnt     <= '0;
         to_flag <= 1'b0;
      end else begin
         cnt <= (state == REQ) ? cnt + CW'(1) : '0;
         if (tmo) to_flag <= 1'b1;
      end
   assign o_timeout = to_flag;
`else
   assign tmo       = 1'b0;
   assign o_timeout = 1'b0;
`endif
   vic_prio_stack #(.N(DEPTH)) u_stack (
      .clk   (i_clk),
      .rst   (i_rst),
      .push  (take),
      .pop   (i_cpu_eoi),
      .din   (ent),
      .top   (top),
      .depth (o_depth),
      .full  (o_full),
      .empty (empty)
   );
   assign o_irq_ack  = ack;
   assign o_cpu_irq  = state == REQ;
   assign o_cpu_vec  = vec;
   assign o_cur_prio = top.prio;
   assign o_err      = err;
endmodule

// File: tb/tb_vic_nest_ctrl.sv
// tb_vic_nest_ctrl: table-driven check of vic_nest_ctrl plus a hand-written ack-timeout sequence.
module tb_vic_nest_ctrl;
   import vic_pkg::*;
   logic                    clk = 1'b0;
   logic                    rst = 1'b0;
   logic                    irq_req = 1'b0;
   logic [VEC_W-1:0]        irq_addr = '0;
   logic [N_IRQ*PRIO_W-1:0] prio = '0;
   logic                    irq_ack, cpu_irq, cpu_ack = 1'b0, cpu_eoi = 1'b0;
   logic [VEC_W-1:0]        cpu_vec;
   logic [PRIO_W-1:0]       cur_prio;
   logic [DEPTH_W-1:0]      depth;
   logic                    full, err, timeout;
   int                      checks = 0;
   int                      errors = 0;
`ifdef VIC_NEST_TIMEOUT_EN
   localparam bit TO = 1'b1;
`else
   localparam bit TO = 1'b0;
`endif
   typedef struct {
      logic r, q;
      logic [4:0] a;
      logic k, e;
      logic [15:0] exp;
   } vec_t;
   vec_t tv[$];
   always #5 clk = ~clk;
   vic_nest_ctrl dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_irq_req  (irq_req),
      .i_irq_addr (irq_addr),
      .i_prio     (prio),
      .o_irq_ack  (irq_ack),
      .o_cpu_irq  (cpu_irq),
      .o_cpu_vec  (cpu_vec),
      .i_cpu_ack  (cpu_ack),
      .i_cpu_eoi  (cpu_eoi),
      .o_cur_prio (cur_prio),
      .o_depth    (depth),
      .o_full     (full),
      .o_err      (err),
      .o_timeout  (timeout)
   );
   function automatic vec_t mk(int r, int q, int a, int k, int e, int ia, int ci, int cv, int cp, int d, int f, int er);
      vec_t v;
      v.r = 1'(r); v.q = 1'(q); v.a = 5'(a); v.k = 1'(k); v.e = 1'(e);
      v.exp = {1'(ia), 1'(ci), 5'(cv), 3'(cp), 3'(d), 1'(f), 1'(er), 1'b0};
      return v;
   endfunction
   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, got, exp);
      end
   endtask
   task automatic drive(logic r, logic q, logic [4:0] a, logic k, logic e);
      rst = r; irq_req = q; irq_addr = a; cpu_ack = k; cpu_eoi = e;
   endtask
   initial begin
      prio[1*3 +: 3]  = 3'd0;
      prio[2*3 +: 3]  = 3'd1;
      prio[3*3 +: 3]  = 3'd2;
      prio[4*3 +: 3]  = 3'd3;
      prio[5*3 +: 3]  = 3'd4;
      prio[7*3 +: 3]  = 3'd5;
      prio[9*3 +: 3]  = 3'd2;
      prio[11*3 +: 3] = 3'd7;
      prio[30*3 +: 3] = 3'd6;
      //           r q  a k e  ia ci cv cp d f er
      tv.push_back(mk(1,0, 0,0,0, 0,0, 0,0,0,0,0));
      tv.push_back(mk(0,0, 0,0,0, 0,0, 0,0,0,0,0));
      tv.push_back(mk(0,1, 3,0,0, 1,1, 3,0,0,0,0));
      tv.push_back(mk(0,1, 7,0,0, 0,1, 3,0,0,0,0));
      tv.push_back(mk(0,0, 0,1,0, 0,0, 3,2,1,0,0));
      tv.push_back(mk(0,0, 0,0,1, 0,0, 3,0,0,0,0));
      tv.push_back(mk(0,1, 3,0,0, 1,1, 3,0,0,0,0));
      tv.push_back(mk(0,0, 0,1,0, 0,0, 3,2,1,0,0));
      tv.push_back(mk(0,1, 7,0,0, 1,1, 7,2,1,0,0));
      tv.push_back(mk(0,0, 0,1,0, 0,0, 7,5,2,0,0));
      tv.push_back(mk(0,0, 0,0,1, 0,0, 7,2,1,0,0));
      tv.push_back(mk(0,0, 0,0,1, 0,0, 7,0,0,0,0));
      tv.push_back(mk(0,1, 3,0,0, 1,1, 3,0,0,0,0));
      tv.push_back(mk(0,0, 0,1,0, 0,0, 3,2,1,0,0));
      tv.push_back(mk(0,1, 9,0,0, 0,0, 3,2,1,0,0));
      tv.push_back(mk(0,1, 1,0,0, 0,0, 3,2,1,0,0));
      tv.push_back(mk(0,1,31,0,0, 0,0, 3,2,1,0,0));
      tv.push_back(mk(0,0, 0,0,1, 0,0, 3,0,0,0,0));
      tv.push_back(mk(0,1, 1,0,0, 0,0, 3,0,0,0,0));
      tv.push_back(mk(0,1,31,0,0, 0,0, 3,0,0,0,0));
      tv.push_back(mk(0,1, 2,0,0, 1,1, 2,0,0,0,0));
      tv.push_back(mk(0,0, 0,1,0, 0,0, 2,1,1,0,0));
      tv.push_back(mk(0,1, 3,0,0, 1,1, 3,1,1,0,0));
      tv.push_back(mk(0,0, 0,1,0, 0,0, 3,2,2,0,0));
      tv.push_back(mk(0,1, 4,0,0, 1,1, 4,2,2,0,0));
      tv.push_back(mk(0,0, 0,1,0, 0,0, 4,3,3,0,0));
      tv.push_back(mk(0,1, 5,0,0, 1,1, 5,3,3,0,0));
      tv.push_back(mk(0,0, 0,1,0, 0,0, 5,4,4,1,0));
      tv.push_back(mk(0,1,11,0,0, 0,0, 5,4,4,1,0));
      tv.push_back(mk(0,1,11,0,1, 0,0, 5,3,3,0,0));
      tv.push_back(mk(0,1,11,0,0, 1,1,11,3,3,0,0));
      tv.push_back(mk(0,0, 0,1,0, 0,0,11,7,4,1,0));
      tv.push_back(mk(0,0, 0,0,1, 0,0,11,3,3,0,0));
      tv.push_back(mk(0,0, 0,0,1, 0,0,11,2,2,0,0));
      tv.push_back(mk(0,0, 0,0,1, 0,0,11,1,1,0,0));
      tv.push_back(mk(0,0, 0,0,1, 0,0,11,0,0,0,0));
      tv.push_back(mk(0,0, 0,0,1, 0,0,11,0,0,0,1));
      tv.push_back(mk(0,0, 0,0,0, 0,0,11,0,0,0,1));
      tv.push_back(mk(0,1, 3,0,0, 1,1, 3,0,0,0,1));
      tv.push_back(mk(0,0, 0,1,0, 0,0, 3,2,1,0,1));
      tv.push_back(mk(0,1, 7,0,0, 1,1, 7,2,1,0,1));
      tv.push_back(mk(0,0, 0,1,1, 0,0, 7,5,1,0,1));
      tv.push_back(mk(0,0, 0,0,1, 0,0, 7,0,0,0,1));
      tv.push_back(mk(0,0, 0,1,0, 0,0, 7,0,0,0,1));
      tv.push_back(mk(0,1, 3,0,0, 1,1, 3,0,0,0,1));
      tv.push_back(mk(1,0, 0,1,0, 0,0, 0,0,0,0,0));
      tv.push_back(mk(0,0, 0,0,0, 0,0, 0,0,0,0,0));
      tv.push_back(mk(0,1,30,0,0, 1,1,30,0,0,0,0));
      tv.push_back(mk(0,0, 0,1,0, 0,0,30,6,1,0,0));
      tv.push_back(mk(0,0, 0,0,1, 0,0,30,0,0,0,0));
      @(negedge clk);
      foreach (tv[i]) begin
         drive(tv[i].r, tv[i].q, tv[i].a, tv[i].k, tv[i].e);
         @(negedge clk);
         chk($sformatf("row%0d", i),
             32'({irq_ack, cpu_irq, cpu_vec, cur_prio, depth, full, err, timeout}),
             32'(tv[i].exp));
      end
      // an unacknowledged request: held forever, or dropped after TO_CYC cycles with the timeout macro
      drive(0, 1, 3, 0, 0);
      @(negedge clk);
      chk("to_enter", 32'({irq_ack, cpu_irq, cpu_vec}), 32'({1'b1, 1'b1, 5'd3}));
      drive(0, 0, 0, 0, 0);
      begin
         int held = 0;
         for (int c = 1; c < TO_CYC; c++) begin
            @(negedge clk);
            held += int'(cpu_irq && !irq_ack && !timeout);
         end
         chk("to_hold", 32'(held), 32'(TO_CYC - 1));
      end
      @(negedge clk);
      chk("to_expire", 32'({cpu_irq, timeout, depth}), 32'({!TO, TO, 3'd0}));
      drive(0, 0, 0, 1, 0);
      @(negedge clk);
      chk("to_late_ack", 32'({cpu_irq, depth, cur_prio}), 32'({1'b0, (TO ? 3'd0 : 3'd1), (TO ? 3'd0 : 3'd2)}));
      drive(0, 0, 0, 0, 1);
      @(negedge clk);
      chk("to_eoi", 32'({depth, err, timeout}), 32'({3'd0, TO, TO}));
      drive(0, 0, 0, 0, 0);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vic_nest_ctrl.md
Name: vic_nest_ctrl

Overview:
Nesting/priority scheduler between the vic_irq interrupt controller and the CPU core. Accepts the pending vector from vic_irq and looks up a per-line priority. Forwards the vector to the CPU only if its priority is strictly higher than the currently active level. Keeps a LIFO of active {vector, priority} entries, pushed on CPU acknowledge and popped on end-of-interrupt (EOI), so interrupts can nest.

Parameters:
N_IRQ, 31, number of interrupt lines (matches vic_irq)
VEC_W, 5, vector width
PRIO_W, 3, priority width; 0 = masked, 7 = highest
DEPTH, 4, maximum nesting depth (stack entries)
TO_CYC, 64, CPU acknowledge timeout in cycles (used only with VIC_NEST_TIMEOUT_EN)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_irq_req  in  1  pending request from vic_irq (its o_IRQ)
i_irq_addr  in  VEC_W  pending vector from vic_irq (its o_irq_addr)
i_prio  in  N_IRQ*PRIO_W  per-line priority; line k at bits [k*PRIO_W +: PRIO_W]
o_irq_ack  out  1  one-cycle accept pulse to vic_irq (its i_IRQ)
o_cpu_irq  out  1  interrupt request to CPU
o_cpu_vec  out  VEC_W  vector presented to CPU
i_cpu_ack  in  1  CPU has taken the vector (one-cycle pulse)
i_cpu_eoi  in  1  CPU finished the current handler (one-cycle pulse)
o_cur_prio  out  PRIO_W  priority at top of stack; 0 when empty
o_depth  out  clog2(DEPTH+1)  number of stacked entries
o_full  out  1  depth == DEPTH
o_err  out  1  sticky: EOI received with empty stack
o_timeout  out  1  sticky: ack timeout (0 without macro)

Behaviour:
- Reset (i_rst sampled high at posedge): state IDLE; stack empty; o_irq_ack, o_cpu_irq, o_err, o_timeout = 0; o_cpu_vec = 0; o_cur_prio = 0; o_depth = 0. Reset overrides all other inputs, including mid-REQ.
- p = i_prio[i_irq_addr]. An i_irq_addr >= N_IRQ is treated as p = 0.
- IDLE: if i_irq_req && p > o_cur_prio && !o_full, then at the next edge: o_irq_ack = 1 for exactly one cycle, o_cpu_vec = i_irq_addr, captured prio = p, o_cpu_irq = 1, state → REQ. Latency is 1 cycle from the sampled request. Otherwise no ack is issued and the request stays pending in vic_irq.
- REQ: o_cpu_irq held at 1 and o_cpu_vec stable. New vic requests are not sampled. On i_cpu_ack: push {vec, prio}, o_cur_prio = prio, depth + 1, o_cpu_irq = 0 at the next edge, state → IDLE.
- EOI, any state: if depth > 0, pop; o_cur_prio becomes the new top's priority, or 0 if the stack is empty. If depth == 0, set o_err; no other effect.
- Ack and EOI in the same REQ cycle: pop first, then push. Net depth is unchanged and the top is the new entry.
- i_cpu_ack outside REQ is ignored.
- Priority equal to o_cur_prio is never accepted (no self-preemption). Priority 0 is never accepted.
- Full stack: requests are not accepted and no ack is issued, whatever their priority.

Optional Feature:
VIC_NEST_TIMEOUT_EN
- Defined: a counter runs in REQ. If TO_CYC cycles pass without i_cpu_ack, o_cpu_irq drops, o_timeout is set (sticky), nothing is pushed, state → IDLE.
- Undefined: no counter; REQ waits indefinitely; o_timeout is tied to 0.

Decomposition:
- Package vic_pkg: N_IRQ, VEC_W, PRIO_W constants; state enum {IDLE, REQ}; stack entry struct {vec, prio}.
- Sub-module vic_prio_stack: DEPTH-entry LIFO with push/pop/same-cycle push+pop, top, depth, full and empty outputs.

Test Plan:
- Single IRQ: prio[3] = 2, req with addr 3 → ack pulse and o_cpu_irq one cycle later, o_cpu_vec = 3; cpu_ack → depth 1, cur_prio 2; eoi → depth 0, cur_prio 0.
- Nesting: line 3 (prio 2) active; req on line 7 (prio 5) → forwarded, depth 2, cur_prio 5; eoi → cur_prio 2; eoi → 0.
- Blocking: line 3 (prio 2) active; req on line 9 (prio 2) and then line 1 (prio 0) → no ack, o_cpu_irq stays 0, depth stays 1.
- Full: DEPTH = 4 with priorities 1..4 stacked; req at prio 7 → no ack, o_full = 1; one eoi → request accepted next cycle.
- Edge cases: eoi with empty stack → o_err = 1 and depth stays 0; ack and eoi in the same REQ cycle with depth 1 → depth stays 1 and cur_prio = the new priority; i_rst during REQ → all outputs back to reset values next cycle.
- With VIC_NEST_TIMEOUT_EN and TO_CYC = 8: no cpu_ack → o_cpu_irq drops after 8 cycles, o_timeout = 1, depth unchanged.
